// File: rtl/bridge_pkg.sv
// Shared types for the UART-AXI4 bridge response path: arbiter FSM states and
// the per-source response request bundle presented to Frame_Builder.
package bridge_pkg;

   localparam int RESP_DATA_BYTES = 64;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_RELEASE   = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic [7:0]                       status;
      logic [7:0]                       cmd;
      logic [31:0]                      addr;
      logic [5:0]                       count;
      logic                             is_read;
      logic [RESP_DATA_BYTES-1:0][7:0]  data;
   } resp_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the pointer only matters when both sources request.
module rr_arbiter2 (
   input  logic [1:0] i_valid,
   input  logic       i_rr_ptr,
   output logic       o_any,
   output logic       o_winner
);

   assign o_any    = |i_valid;
   assign o_winner = (&i_valid) ? i_rr_ptr : i_valid[1];

endmodule

// File: rtl/frame_response_arbiter.sv
// Shares one Frame_Builder between the AXI result path (req0) and the parser
// NAK path (req1): round-robin grant, one-cycle launch, watchdog-bounded wait.
module frame_response_arbiter
   import bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req0_valid,
   input  logic [7:0]                       req0_status,
   input  logic [7:0]                       req0_cmd,
   input  logic [31:0]                      req0_addr,
   input  logic [5:0]                       req0_count,
   input  logic                             req0_is_read,
   input  logic [RESP_DATA_BYTES-1:0][7:0]  req0_data,
   output logic                             req0_done,
   input  logic                             req1_valid,
   input  logic [7:0]                       req1_status,
   input  logic [7:0]                       req1_cmd,
   input  logic [31:0]                      req1_addr,
   input  logic [5:0]                       req1_count,
   input  logic                             req1_is_read,
   input  logic [RESP_DATA_BYTES-1:0][7:0]  req1_data,
   output logic                             req1_done,
   output logic                             done_timeout,
   output logic [7:0]                       fb_status_code,
   output logic [7:0]                       fb_cmd_echo,
   output logic [31:0]                      fb_addr_echo,
   output logic [RESP_DATA_BYTES-1:0][7:0]  fb_response_data,
   output logic [5:0]                       fb_response_data_count,
   output logic                             fb_is_read_response,
   output logic                             fb_build_response,
   input  logic                             fb_builder_busy,
   input  logic                             fb_response_complete,
   output logic                             grant_idx,
   output logic                             arb_busy,
   output logic [CNT_W-1:0]                 frames_sent,
   output logic [7:0]                       timeout_count
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   arb_state_t       r_state;
   arb_state_t       w_next_state;
   logic             r_grant_idx;
   logic             r_rr_ptr;
   logic             r_build;
   logic             r_done0;
   logic             r_done1;
   logic             r_done_timeout;
   logic [WD_W-1:0]  r_watchdog;
   logic [CNT_W-1:0] r_frames_sent;
   logic [7:0]       r_timeout_count;
   logic             w_any;
   logic             w_winner;
   logic             w_expire;
   logic             w_launch;
   resp_req_t        w_req [2];
   resp_req_t        w_sel;

   rr_arbiter2 u_rr (
      .i_valid  ({req1_valid, req0_valid}),
      .i_rr_ptr (r_rr_ptr),
      .o_any    (w_any),
      .o_winner (w_winner)
   );

   assign w_req[0] = '{status: req0_status, cmd: req0_cmd, addr: req0_addr,
                       count: req0_count, is_read: req0_is_read, data: req0_data};
   assign w_req[1] = '{status: req1_status, cmd: req1_cmd, addr: req1_addr,
                       count: req1_count, is_read: req1_is_read, data: req1_data};

   // Fields follow the owner in every state so they are stable around the launch.
   assign w_sel                  = w_req[r_grant_idx];
   assign fb_status_code         = w_sel.status;
   assign fb_cmd_echo            = w_sel.cmd;
   assign fb_addr_echo           = w_sel.addr;
   assign fb_response_data       = w_sel.data;
   assign fb_response_data_count = w_sel.count;
   assign fb_is_read_response    = w_sel.is_read;

   assign fb_build_response = r_build;
   assign req0_done         = r_done0;
   assign req1_done         = r_done1;
   assign done_timeout      = r_done_timeout;
   assign grant_idx         = r_grant_idx;
   assign arb_busy          = (r_state != ST_IDLE);
   assign frames_sent       = r_frames_sent;
   assign timeout_count     = r_timeout_count;
   assign w_launch          = (r_state == ST_IDLE) && (w_next_state == ST_LAUNCH);

   always_comb begin
      w_next_state = r_state;
      w_expire     = 1'b0;
      case (r_state)
         ST_IDLE:      if (w_any && !fb_builder_busy) w_next_state = ST_LAUNCH;
         ST_LAUNCH:    w_next_state = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            // A completion landing on the expiry cycle still counts as success.
            if (fb_response_complete) begin
               w_next_state = ST_RELEASE;
            end else if (r_watchdog == WD_LAST) begin
               w_next_state = ST_RELEASE;
               w_expire     = 1'b1;
            end
         end
         ST_RELEASE:   w_next_state = ST_IDLE;
         default:      w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_grant_idx     <= 1'b0;
         r_rr_ptr        <= 1'b0;
         r_build         <= 1'b0;
         r_done0         <= 1'b0;
         r_done1         <= 1'b0;
         r_done_timeout  <= 1'b0;
         r_watchdog      <= '0;
         r_frames_sent   <= '0;
         r_timeout_count <= '0;
      end else begin
         r_state        <= w_next_state;
         r_build        <= w_launch;
         r_done0        <= (w_next_state == ST_RELEASE) && !r_grant_idx;
         r_done1        <= (w_next_state == ST_RELEASE) && r_grant_idx;
         r_done_timeout <= w_expire;
         r_watchdog     <= (r_state == ST_WAIT_DONE) ? r_watchdog + WD_W'(1) : '0;
         if (w_launch) r_grant_idx <= w_winner;
         if (r_state == ST_RELEASE) begin
            r_rr_ptr <= ~r_grant_idx;
            if (!r_done_timeout) r_frames_sent <= r_frames_sent + CNT_W'(1);
         end
         if (w_expire && (r_timeout_count != 8'hFF))
            r_timeout_count <= r_timeout_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_frame_response_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model of the arbiter held in the bench.
module tb_frame_response_arbiter;

   localparam int T     = 16;
   localparam int NB    = 64;
   localparam int CNT_W = 16;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0]          req0_status = '0, req1_status = '0;
   logic [7:0]          req0_cmd = '0, req1_cmd = '0;
   logic [31:0]         req0_addr = '0, req1_addr = '0;
   logic [5:0]          req0_count = '0, req1_count = '0;
   logic                req0_is_read = 1'b0, req1_is_read = 1'b0;
   logic [NB-1:0][7:0]  req0_data = '0, req1_data = '0;
   logic                req0_done, req1_done, done_timeout;
   logic [7:0]          fb_status_code, fb_cmd_echo;
   logic [31:0]         fb_addr_echo;
   logic [NB-1:0][7:0]  fb_response_data;
   logic [5:0]          fb_response_data_count;
   logic                fb_is_read_response, fb_build_response;
   logic                fb_builder_busy = 1'b0, fb_response_complete = 1'b0;
   logic                grant_idx, arb_busy;
   logic [CNT_W-1:0]    frames_sent;
   logic [7:0]          timeout_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   frame_response_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_status(req0_status), .req0_cmd(req0_cmd),
      .req0_addr(req0_addr), .req0_count(req0_count), .req0_is_read(req0_is_read),
      .req0_data(req0_data), .req0_done(req0_done),
      .req1_valid(req1_valid), .req1_status(req1_status), .req1_cmd(req1_cmd),
      .req1_addr(req1_addr), .req1_count(req1_count), .req1_is_read(req1_is_read),
      .req1_data(req1_data), .req1_done(req1_done),
      .done_timeout(done_timeout),
      .fb_status_code(fb_status_code), .fb_cmd_echo(fb_cmd_echo),
      .fb_addr_echo(fb_addr_echo), .fb_response_data(fb_response_data),
      .fb_response_data_count(fb_response_data_count),
      .fb_is_read_response(fb_is_read_response),
      .fb_build_response(fb_build_response),
      .fb_builder_busy(fb_builder_busy), .fb_response_complete(fb_response_complete),
      .grant_idx(grant_idx), .arb_busy(arb_busy),
      .frames_sent(frames_sent), .timeout_count(timeout_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_data(input logic [NB-1:0][7:0] act, input logic [NB-1:0][7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         for (int b = 0; b < NB; b++) begin
            if (act[b] !== exp[b]) begin
               $display("FAIL fb_data byte %0d actual=%0h required=%0h t=%0t",
                        b, act[b], exp[b], $time);
               break;
            end
         end
      end
   endtask

   // ---------------- behavioural model ----------------
   // A frame is: launch cycle (age 0), wait cycles (age 1..T), then one
   // closing cycle that reports done (ending 1 = completed, 2 = abandoned).
   bit          m_ready = 0;
   bit          m_in_frame;
   int          m_age;
   int          m_ending;
   bit          m_owner, m_ptr;
   logic [15:0] m_frames;
   int          m_touts;

   always @(negedge clk) begin
      if (m_ready) begin
         chk("grant_idx", grant_idx, m_owner);
         chk("arb_busy", arb_busy, m_in_frame || (m_ending != 0));
         chk("build", fb_build_response, m_in_frame && (m_age == 0));
         chk("done0", req0_done, (m_ending != 0) && !m_owner);
         chk("done1", req1_done, (m_ending != 0) && m_owner);
         chk("done_timeout", done_timeout, m_ending == 2);
         chk("frames_sent", frames_sent, m_frames);
         chk("timeout_count", timeout_count, m_touts);
         chk("fb_status", fb_status_code, m_owner ? req1_status : req0_status);
         chk("fb_cmd", fb_cmd_echo, m_owner ? req1_cmd : req0_cmd);
         chk("fb_addr", fb_addr_echo, m_owner ? req1_addr : req0_addr);
         chk("fb_count", fb_response_data_count, m_owner ? req1_count : req0_count);
         chk("fb_is_read", fb_is_read_response, m_owner ? req1_is_read : req0_is_read);
         chk_data(fb_response_data, m_owner ? req1_data : req0_data);
      end
      if (rst) begin
         m_ready = 1; m_in_frame = 0; m_age = 0; m_ending = 0;
         m_owner = 0; m_ptr = 0; m_frames = 0; m_touts = 0;
      end else if (m_ready) begin
         if (m_ending != 0) begin
            if (m_ending == 1) m_frames = m_frames + 16'd1;
            m_ptr = !m_owner;
            m_ending = 0;
         end else if (m_in_frame) begin
            if (m_age == 0) m_age = 1;
            else if (fb_response_complete) begin m_ending = 1; m_in_frame = 0; end
            else if (m_age == T) begin
               m_ending = 2; m_in_frame = 0;
               if (m_touts < 255) m_touts++;
            end else m_age++;
         end else if ((req0_valid || req1_valid) && !fb_builder_busy) begin
            m_owner = (req0_valid && req1_valid) ? m_ptr : req1_valid;
            m_in_frame = 1; m_age = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic do_reset();
      rst = 1; req0_valid = 0; req1_valid = 0;
      fb_builder_busy = 0; fb_response_complete = 0;
      tick(); tick();
      rst = 0;
   endtask

   task automatic rand_fields(input int i);
      logic [NB-1:0][7:0] d;
      for (int b = 0; b < NB; b++) d[b] = 8'($urandom);
      if (i == 0) begin
         req0_status = 8'($urandom); req0_cmd = 8'($urandom); req0_addr = $urandom;
         req0_count = 6'($urandom); req0_is_read = 1'($urandom); req0_data = d;
      end else begin
         req1_status = 8'($urandom); req1_cmd = 8'($urandom); req1_addr = $urandom;
         req1_count = 6'($urandom); req1_is_read = 1'($urandom); req1_data = d;
      end
   endtask

   // Waits for a launch, completes it, and returns in the done cycle.
   task automatic serve(output int g);
      int n = 0;
      g = -1;
      while (!fb_build_response && n < 50) begin tick(); n++; end
      checks++;
      if (!fb_build_response) begin
         errors++;
         $display("FAIL serve_launch actual=no_build required=build within 50 cycles");
      end else begin
         g = int'(grant_idx);
         tick();
         fb_response_complete = 1;
         tick();
         fb_response_complete = 0;
         chk("serve_done", g == 1 ? req1_done : req0_done, 1'b1);
      end
   endtask

   bit pend [2];

   task automatic agent(input int i);
      logic v, d;
      v = (i == 0) ? req0_valid : req1_valid;
      d = (i == 0) ? req0_done : req1_done;
      if (pend[i]) begin
         pend[i] = 0;
         if ($urandom_range(0, 3) != 0) v = 0;
      end else if (!v && $urandom_range(0, 2) == 0) begin
         rand_fields(i);
         v = 1;
      end
      if (d) pend[i] = 1;
      if (i == 0) req0_valid = v; else req1_valid = v;
   endtask

   initial begin
      int g, g0, g1;
      do_reset();
      chk("rst_frames", frames_sent, 0);
      chk("rst_touts", timeout_count, 0);
      chk("rst_busy", arb_busy, 0);
      chk("rst_build", fb_build_response, 0);
      chk("rst_grant", grant_idx, 0);

      // single request
      rand_fields(0);
      req0_status = 8'h00; req0_cmd = 8'h81; req0_addr = 32'h1000_0004; req0_count = 6'd4;
      req0_valid = 1;
      tick();
      chk("s1_build", fb_build_response, 1);
      chk("s1_cmd", fb_cmd_echo, 8'h81);
      chk("s1_addr", fb_addr_echo, 32'h1000_0004);
      chk("s1_count", fb_response_data_count, 6'd4);
      tick();
      chk("s1_build_once", fb_build_response, 0);
      tick();
      fb_response_complete = 1;
      tick();
      fb_response_complete = 0;
      chk("s1_done", req0_done, 1);
      chk("s1_done_to", done_timeout, 0);
      req0_valid = 0;
      tick();
      chk("s1_frames", frames_sent, 1);
      chk("s1_done_pulse", req0_done, 0);

      // simultaneous requests
      do_reset();
      rand_fields(0); rand_fields(1);
      req0_valid = 1; req1_valid = 1;
      serve(g0); req0_valid = 0;
      serve(g1); req1_valid = 0;
      chk("s2_first", g0, 0);
      chk("s2_second", g1, 1);
      tick();
      chk("s2_frames", frames_sent, 2);

      // continuous contention
      do_reset();
      req0_valid = 1; req1_valid = 1;
      for (int k = 0; k < 6; k++) begin
         serve(g);
         chk("s3_alternate", g, k % 2);
      end
      req0_valid = 0; req1_valid = 0;
      tick();
      chk("s3_frames", frames_sent, 6);
      chk("s3_model_frames", m_frames, 6);

      // builder busy
      do_reset();
      rand_fields(1);
      fb_builder_busy = 1; req1_valid = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("s4_no_build", fb_build_response, 0);
      end
      fb_builder_busy = 0;
      tick();
      chk("s4_build", fb_build_response, 1);
      chk("s4_grant", grant_idx, 1);
      tick();
      fb_response_complete = 1;
      tick();
      fb_response_complete = 0;
      chk("s4_done1", req1_done, 1);
      req1_valid = 0;

      // watchdog: done exactly T cycles after entering WAIT_DONE
      do_reset();
      rand_fields(0);
      req0_valid = 1;
      tick();
      chk("s5_build", fb_build_response, 1);
      for (int k = 0; k < T; k++) begin
         tick();
         chk("s5_no_done_yet", req0_done, 0);
      end
      tick();
      chk("s5_done", req0_done, 1);
      chk("s5_done_to", done_timeout, 1);
      chk("s5_touts", timeout_count, 1);
      chk("s5_model_touts", m_touts, 1);
      req0_valid = 0;
      tick();
      chk("s5_frames", frames_sent, 0);

      // reset mid-frame
      req0_valid = 1;
      tick(); tick(); tick();
      chk("s6_in_wait", arb_busy, 1);
      rst = 1;
      tick();
      chk("s6_busy", arb_busy, 0);
      chk("s6_done", req0_done, 0);
      chk("s6_build", fb_build_response, 0);
      chk("s6_touts", timeout_count, 0);
      chk("s6_grant", grant_idx, 0);
      rst = 0; req0_valid = 0;
      tick();

      // randomized traffic
      pend[0] = 0; pend[1] = 0;
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 599) == 0);
         fb_builder_busy = ($urandom_range(0, 3) == 0);
         fb_response_complete = ($urandom_range(0, 6) == 0);
         if (rst) begin
            req0_valid = 0; req1_valid = 0; pend[0] = 0; pend[1] = 0;
         end else begin
            agent(0); agent(1);
         end
         tick();
      end
      rst = 0; req0_valid = 0; req1_valid = 0;
      fb_builder_busy = 0; fb_response_complete = 0;
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
